// File: rtl/dmem_arbiter_pkg.sv
// Shared constants, size codes, FSM encoding and the captured-request record for the
// two-port DMEM arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned REG_WIDTH       = 32;
    localparam int unsigned DMEM_ADDR_WIDTH = 10;
    localparam int unsigned DMEM_DEPTH      = 1024;
    localparam int unsigned MEM_WIDTH       = 8;
    localparam int unsigned HALF_WIDTH      = 2 * MEM_WIDTH;
    localparam int unsigned NUM_DMEM_PORTS  = 2;
    localparam int unsigned LANES           = REG_WIDTH / MEM_WIDTH;

    typedef enum logic [1:0] {
        SzByte    = 2'b00,
        SzHalf    = 2'b01,
        SzWord    = 2'b10,
        SzIllegal = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StRmwWr  = 2'b10,
        StResp   = 2'b11
    } state_e;

    typedef struct packed {
        logic                       we;
        size_e                      size;
        logic                       uns;
        logic [DMEM_ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]       wdata;
    } req_t;

    // Misaligned, illegal size or a word that runs past the end of DMEM.
    function automatic logic access_error(input size_e size, input logic [DMEM_ADDR_WIDTH-1:0] addr);
        logic        misaligned;
        logic [31:0] last_byte;
        misaligned = ((size == SzHalf) && addr[0]) || ((size == SzWord) && (addr[1:0] != 2'b00));
        last_byte  = 32'({addr[DMEM_ADDR_WIDTH-1:2], 2'b00}) + 32'd3;
        return (size == SzIllegal) || misaligned || (last_byte >= 32'(DMEM_DEPTH));
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and DMEM signals of the arbiter; master is the requester/memory side,
// slave is the arbiter itself.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic                       p0_req;
    logic                       p0_we;
    logic [1:0]                 p0_size;
    logic                       p0_unsigned;
    logic [DMEM_ADDR_WIDTH-1:0] p0_addr;
    logic [REG_WIDTH-1:0]       p0_wdata;
    logic                       p0_gnt;
    logic                       p0_rvalid;
    logic [REG_WIDTH-1:0]       p0_rdata;
    logic                       p0_err;

    logic                       p1_req;
    logic                       p1_we;
    logic [1:0]                 p1_size;
    logic                       p1_unsigned;
    logic [DMEM_ADDR_WIDTH-1:0] p1_addr;
    logic [REG_WIDTH-1:0]       p1_wdata;
    logic                       p1_gnt;
    logic                       p1_rvalid;
    logic [REG_WIDTH-1:0]       p1_rdata;
    logic                       p1_err;

    logic                       mem_wr_en;
    logic [DMEM_ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]       mem_wr_data;
    logic [REG_WIDTH-1:0]       mem_rd_data;

    modport master (
        output p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_wr_en, mem_addr, mem_wr_data,
        output mem_rd_data
    );

    modport slave (
        input  p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_wr_en, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: merges store data into a word for read-modify-write and
// extracts/extends sub-word load results.
module dmem_lane_unit
    import dmem_arbiter_pkg::*;
(
    input  size_e                size_i,
    input  logic                 uns_i,
    input  logic [1:0]           offset_i,
    input  logic [REG_WIDTH-1:0] word_i,
    input  logic [REG_WIDTH-1:0] wdata_i,
    output logic [REG_WIDTH-1:0] merged_o,
    output logic [REG_WIDTH-1:0] load_o
);

    logic [REG_WIDTH-1:0] shifted;
    logic                 sign_byte;
    logic                 sign_half;

    always_comb begin
        merged_o = word_i;
        for (int i = 0; i < LANES; i++) begin
            case (size_i)
                SzByte: begin
                    if (2'(i) == offset_i) begin
                        merged_o[i*MEM_WIDTH +: MEM_WIDTH] = wdata_i[MEM_WIDTH-1:0];
                    end
                end
                SzHalf: begin
                    // Half lane i/2 takes the low or high byte of wdata by i's parity.
                    if ((i / 2) == int'(offset_i[1])) begin
                        merged_o[i*MEM_WIDTH +: MEM_WIDTH] = wdata_i[(i % 2)*MEM_WIDTH +: MEM_WIDTH];
                    end
                end
                SzWord: begin
                    merged_o[i*MEM_WIDTH +: MEM_WIDTH] = wdata_i[i*MEM_WIDTH +: MEM_WIDTH];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        shifted   = word_i >> (32'(offset_i) * MEM_WIDTH);
        sign_byte = ~uns_i & shifted[MEM_WIDTH-1];
        sign_half = ~uns_i & shifted[HALF_WIDTH-1];
        case (size_i)
            SzByte:  load_o = {{(REG_WIDTH-MEM_WIDTH){sign_byte}}, shifted[MEM_WIDTH-1:0]};
            SzHalf:  load_o = {{(REG_WIDTH-HALF_WIDTH){sign_half}}, shifted[HALF_WIDTH-1:0]};
            default: load_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between two DMEM requesters, sequencing each access onto the
// single word-wide memory port with read-modify-write for sub-word stores.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input logic           clk,
    input logic           reset_n,
    dmem_arbiter_if.slave bus
);

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 owner_q, owner_d;
    req_t                 req_q, req_d;
    logic                 err_q, err_d;
    logic [REG_WIDTH-1:0] rd_word_q, rd_word_d;

    logic                 any_req;
    logic                 winner;
    req_t                 win_req;
    logic                 grant;
    logic                 rvalid;
    logic                 wr_en;
    logic [REG_WIDTH-1:0] wr_data;
    logic [REG_WIDTH-1:0] merged;
    logic [REG_WIDTH-1:0] load_val;
    logic [REG_WIDTH-1:0] resp_data;

    // On a tie the port that was not granted last wins.
    always_comb begin
        any_req       = bus.p0_req | bus.p1_req;
        winner        = (bus.p0_req & bus.p1_req) ? ~last_q : bus.p1_req;
        win_req.we    = winner ? bus.p1_we       : bus.p0_we;
        win_req.size  = size_e'(winner ? bus.p1_size : bus.p0_size);
        win_req.uns   = winner ? bus.p1_unsigned : bus.p0_unsigned;
        win_req.addr  = winner ? bus.p1_addr     : bus.p0_addr;
        win_req.wdata = winner ? bus.p1_wdata    : bus.p0_wdata;
    end

    dmem_lane_unit u_lane (
        .size_i   (req_q.size),
        .uns_i    (req_q.uns),
        .offset_i (req_q.addr[1:0]),
        .word_i   (rd_word_q),
        .wdata_i  (req_q.wdata),
        .merged_o (merged),
        .load_o   (load_val)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        req_d     = req_q;
        err_d     = err_q;
        rd_word_d = rd_word_q;
        grant     = 1'b0;
        rvalid    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant   = 1'b1;
                    req_d   = win_req;
                    owner_d = winner;
                    last_d  = winner;
                    err_d   = access_error(win_req.size, win_req.addr);
                    state_d = err_d ? StResp : StAccess;
                end
            end
            StAccess: begin
                if (req_q.we && (req_q.size == SzWord)) begin
                    wr_en   = 1'b1;
                    wr_data = req_q.wdata;
                    state_d = StResp;
                end else begin
                    rd_word_d = bus.mem_rd_data;
                    state_d   = req_q.we ? StRmwWr : StResp;
                end
            end
            StRmwWr: begin
                wr_en   = 1'b1;
                wr_data = merged;
                state_d = StResp;
            end
            StResp: begin
                rvalid  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            req_q     <= '0;
            err_q     <= 1'b0;
            rd_word_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            req_q     <= req_d;
            err_q     <= err_d;
            rd_word_q <= rd_word_d;
        end
    end

    // Reset gates the combinational strobes so nothing leaks out while reset_n is low.
    always_comb begin
        resp_data       = (rvalid && !req_q.we && !err_q) ? load_val : '0;
        bus.p0_gnt      = grant & ~winner & reset_n;
        bus.p1_gnt      = grant & winner & reset_n;
        bus.p0_rvalid   = rvalid & ~owner_q;
        bus.p1_rvalid   = rvalid & owner_q;
        bus.p0_err      = rvalid & ~owner_q & err_q;
        bus.p1_err      = rvalid & owner_q & err_q;
        bus.p0_rdata    = owner_q ? '0 : resp_data;
        bus.p1_rdata    = owner_q ? resp_data : '0;
        bus.mem_wr_en   = wr_en & reset_n;
        bus.mem_addr    = {req_q.addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
        bus.mem_wr_data = wr_data;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter against a byte-addressed reference memory model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] dmem [DMEM_DEPTH/4];
    logic [7:0]  ref_mem [DMEM_DEPTH];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          wr_pulses = 0;
    int          rv_pulses = 0;
    int          bad_addr = 0;

    assign bus.mem_rd_data = dmem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (bus.mem_wr_en) dmem[bus.mem_addr[9:2]] <= bus.mem_wr_data;
        else if (poke_en) dmem[poke_addr[9:2]] <= poke_data;
    end

    always @(negedge clk) begin
        if (bus.mem_wr_en) begin
            wr_pulses <= wr_pulses + 1;
            if (bus.mem_addr[1:0] != 2'b00) bad_addr <= bad_addr + 1;
        end
        if (bus.p0_rvalid || bus.p1_rvalid) rv_pulses <= rv_pulses + 1;
    end

    function automatic logic gnt_of(input int p);
        return (p != 0) ? bus.p1_gnt : bus.p0_gnt;
    endfunction
    function automatic logic rvalid_of(input int p);
        return (p != 0) ? bus.p1_rvalid : bus.p0_rvalid;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p != 0) ? bus.p1_rdata : bus.p0_rdata;
    endfunction
    function automatic logic err_of(input int p);
        return (p != 0) ? bus.p1_err : bus.p0_err;
    endfunction

    function automatic logic [31:0] ref_word(input int byte_addr);
        int b;
        b = byte_addr & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // Reference: little-endian byte memory, access rules applied byte by byte.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [9:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata,
                                  output int lat, output int writes);
        int a;
        int n;
        logic [31:0] v;
        a = int'(addr);
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || ((a & ~3) + 3 >= int'(DMEM_DEPTH));
        rdata = '0;
        writes = 0;
        lat = 1;
        if (err) return;
        n = 1 << size;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a+i] = wdata[8*i +: 8];
            writes = 1;
            lat = (n == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rdata = v;
            lat = 2;
        end
    endfunction

    task automatic drive_port(input int p, input logic req, input logic we, input logic [1:0] size,
                              input logic uns, input logic [9:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_size = size;
            bus.p0_unsigned = uns; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_size = size;
            bus.p1_unsigned = uns; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        int b;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        b = int'(a) & ~3;
        for (int i = 0; i < 4; i++) ref_mem[b+i] = d[8*i +: 8];
    endtask

    // One complete access on one port, checked against the model.
    task automatic access(input int p, input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wdata, input string name,
                          output int gnt_wait);
        logic        e_err, r_err;
        logic [31:0] e_rdata, r_data;
        int          e_lat, e_wr, w0, cyc, lat;
        logic        got;
        model(we, size, uns, addr, wdata, e_err, e_rdata, e_lat, e_wr);
        w0 = wr_pulses;
        drive_port(p, 1'b1, we, size, uns, addr, wdata);
        cyc = 0;
        @(negedge clk);
        while (!gnt_of(p) && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        gnt_wait = cyc;
        n_vec++;
        if (!gnt_of(p)) begin
            n_err++;
            $display("FAIL %s gnt: none after %0d cycles, required a gnt", name, cyc);
            @(posedge clk); #1;
            drive_port(p, 1'b0, we, size, uns, addr, wdata);
            return;
        end
        @(posedge clk); #1;
        drive_port(p, 1'b0, we, size, uns, addr, wdata);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = rvalid_of(p);
        end
        r_data = rdata_of(p);
        r_err = err_of(p);
        @(posedge clk); #1;
        n_vec++;
        if (!got || lat != e_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d (rvalid=%0b), required %0d", name, lat, got, e_lat);
        end
        n_vec++;
        if (r_err !== e_err) begin
            n_err++;
            $display("FAIL %s err: got %0b, required %0b", name, r_err, e_err);
        end
        n_vec++;
        if (r_data !== e_rdata) begin
            n_err++;
            $display("FAIL %s rdata: got %08h, required %08h", name, r_data, e_rdata);
        end
        n_vec++;
        if (wr_pulses - w0 != e_wr) begin
            n_err++;
            $display("FAIL %s mem_wr_en pulses: got %0d, required %0d", name, wr_pulses - w0, e_wr);
        end
        n_vec++;
        if (dmem[addr[9:2]] !== ref_word(int'(addr))) begin
            n_err++;
            $display("FAIL %s mem word: got %08h, required %08h", name, dmem[addr[9:2]],
                     ref_word(int'(addr)));
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 10'h0, 32'h0);
        drive_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 10'h4, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset strobes: got %06b, required 000000", {bus.p0_gnt, bus.p1_gnt,
                     bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err});
        end
        n_vec++;
        if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset rdata: got %08h/%08h, required 0", bus.p0_rdata, bus.p1_rdata);
        end
        n_vec++;
        if (bus.mem_addr !== 10'h0 || bus.mem_wr_data !== 32'h0 || bus.mem_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset mem: got addr %03h data %08h we %0b, required 0", bus.mem_addr,
                     bus.mem_wr_data, bus.mem_wr_en);
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 2'b10, 1'b0, 10'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 2'b10, 1'b0, 10'h0, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < int'(DMEM_DEPTH / 4); i++) poke(10'(i * 4), $urandom);
    endtask

    task automatic test_word();
        int w;
        access(0, 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, "word_store", w);
        access(0, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, "word_load", w);
    endtask

    task automatic test_rmw();
        int w;
        poke(10'h020, 32'h11223344);
        access(1, 1'b1, 2'b00, 1'b0, 10'h022, 32'h000000AB, "rmw_byte", w);
        n_vec++;
        if (dmem[8] !== 32'h11AB3344) begin
            n_err++;
            $display("FAIL rmw_byte word: got %08h, required 11ab3344", dmem[8]);
        end
        access(1, 1'b1, 2'b01, 1'b0, 10'h020, 32'h0000BEEF, "rmw_half", w);
        n_vec++;
        if (dmem[8] !== 32'h11ABBEEF) begin
            n_err++;
            $display("FAIL rmw_half word: got %08h, required 11abbeef", dmem[8]);
        end
    endtask

    task automatic test_load_ext();
        int w;
        poke(10'h040, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) access(i % 2, 1'b0, 2'b00, 1'b0, 10'(64 + i), 32'h0, "ld_byte_s", w);
        access(0, 1'b0, 2'b01, 1'b1, 10'h042, 32'h0, "ld_half_u", w);
        access(1, 1'b0, 2'b01, 1'b0, 10'h042, 32'h0, "ld_half_s", w);
    endtask

    task automatic test_contention();
        int order[$];
        int cyc;
        int w;
        reset_n = 1'b0;
        drive_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 10'h100, 32'h0);
        drive_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 10'h104, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        while (order.size() < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.p0_gnt) order.push_back(0);
            if (bus.p1_gnt) order.push_back(1);
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 2'b10, 1'b0, 10'h100, 32'h0);
        drive_port(1, 1'b0, 1'b0, 2'b10, 1'b0, 10'h104, 32'h0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= order.size() || order[i] != (i % 2)) begin
                n_err++;
                $display("FAIL contention grant %0d: got port %0d, required port %0d", i,
                         (i < order.size()) ? order[i] : -1, i % 2);
            end
        end
        repeat (6) @(posedge clk);
        #1;
        access(1, 1'b0, 2'b10, 1'b0, 10'h104, 32'h0, "lone_p1", w);
        n_vec++;
        if (w != 0) begin
            n_err++;
            $display("FAIL lone_p1 gnt wait: got %0d cycles, required 0", w);
        end
    endtask

    task automatic test_errors();
        int w;
        access(0, 1'b0, 2'b10, 1'b0, 10'h005, 32'h0, "err_word_misalign", w);
        access(1, 1'b1, 2'b01, 1'b0, 10'h003, 32'h12345678, "err_half_misalign", w);
        access(0, 1'b1, 2'b11, 1'b0, 10'h008, 32'hFFFFFFFF, "err_size", w);
        access(1, 1'b1, 2'b10, 1'b0, 10'(DMEM_DEPTH - 2), 32'hA5A5A5A5, "err_range", w);
    endtask

    task automatic test_reset_mid_rmw();
        int w0, r0, cyc;
        poke(10'h030, 32'hCAFEF00D);
        w0 = wr_pulses;
        r0 = rv_pulses;
        drive_port(0, 1'b1, 1'b1, 2'b00, 1'b0, 10'h031, 32'h00000055);
        cyc = 0;
        @(negedge clk);
        while (!bus.p0_gnt && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 10'h030, 32'h0);
        drive_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 10'h034, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (wr_pulses != w0 || rv_pulses != r0) begin
            n_err++;
            $display("FAIL reset_mid_rmw pulses: got %0d writes %0d rvalids, required 0 0",
                     wr_pulses - w0, rv_pulses - r0);
        end
        n_vec++;
        if (dmem[12] !== ref_word(12'h030)) begin
            n_err++;
            $display("FAIL reset_mid_rmw word: got %08h, required %08h", dmem[12], ref_word(32'h030));
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_rmw first tie: got gnt p0=%0b p1=%0b, required p0=1 p1=0",
                     bus.p0_gnt, bus.p1_gnt);
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, 2'b10, 1'b0, 10'h030, 32'h0);
        cyc = 0;
        @(negedge clk);
        while (!bus.p1_gnt && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        drive_port(1, 1'b0, 1'b0, 2'b10, 1'b0, 10'h034, 32'h0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int p, r, w;
        logic we, uns;
        logic [1:0] size;
        logic [9:0] addr;
        for (int n = 0; n < 80; n++) begin
            p = $urandom_range(0, 1);
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr = 10'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) addr = 10'(DMEM_DEPTH - $urandom_range(1, 8));
            access(p, we, size, uns, addr, $urandom, "random", w);
        end
    endtask

    task automatic test_final_memory();
        int bad;
        bad = 0;
        for (int i = 0; i < int'(DMEM_DEPTH / 4); i++) begin
            if (dmem[i] !== ref_word(i * 4)) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL final memory: got %0d differing words, required 0", bad);
        end
        n_vec++;
        if (bad_addr != 0) begin
            n_err++;
            $display("FAIL write address alignment: got %0d unaligned writes, required 0", bad_addr);
        end
    endtask

    initial begin
        drive_port(0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
        test_reset();
        init_mem();
        test_word();
        test_rmw();
        test_load_ext();
        test_contention();
        test_errors();
        test_reset_mid_rmw();
        test_random();
        test_final_memory();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
